// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: MEM/WB register, result mux, 32x32 regfile with two read ports.
// Latency: M inputs appear on W outputs one edge later; regfile commit one edge after that; reads are combinational.
// Backpressure: StallW_i holds the MEM/WB register (the write repeats harmlessly); FlushW_i inserts a bubble and wins over stall.
// Optional feature: define WB_REGFILE_BYPASS_EN to forward the in-flight writeback value onto the read ports.
module wb_regfile (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        RegWriteM_i,
  input  logic [1:0]  ResultSrcM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] ReadDataM_i,
  input  logic [31:0] PCPlus4M_i,
  input  logic [4:0]  RdM_i,
  input  logic        StallW_i,
  input  logic        FlushW_i,
  input  logic [4:0]  A1D_i,
  input  logic [4:0]  A2D_i,
  output logic [31:0] RD1D_o,
  output logic [31:0] RD2D_o,
  output logic [31:0] ResultW_o,
  output logic [4:0]  RdW_o,
  output logic        RegWriteW_o,
  output logic [31:0] a0_o
);

  // MEM/WB pipeline register fields
  logic        reg_write_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus4_w;
  logic [4:0]  rd_w;

  // x1..x31; x0 is hardwired to zero and has no storage
  logic [31:0] regs [1:31];

  logic [31:0] result_w;
  logic        wr_en;
  logic [31:0] rd1_stored;
  logic [31:0] rd2_stored;

  // MEM/WB register: reset, then flush (bubble), then stall (hold), else load
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= '0;
    end else if (FlushW_i) begin
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= '0;
    end else if (!StallW_i) begin
      reg_write_w  <= RegWriteM_i;
      result_src_w <= ResultSrcM_i;
      alu_result_w <= ALUResultM_i;
      read_data_w  <= ReadDataM_i;
      pc_plus4_w   <= PCPlus4M_i;
      rd_w         <= RdM_i;
    end
  end

  // Result select; code 11 is never issued by control and yields zero
  always_comb begin
    result_w = '0;
    case (result_src_w)
      2'b00:   result_w = alu_result_w;
      2'b01:   result_w = read_data_w;
      2'b10:   result_w = pc_plus4_w;
      default: result_w = '0;
    endcase
  end

  assign wr_en = reg_write_w && (rd_w != 5'd0);

  // Register file commit; writes to x0 are dropped by wr_en
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd_w] <= result_w;
    end
  end

  // Stored-content reads; address 0 reads as zero
  always_comb begin
    rd1_stored = '0;
    rd2_stored = '0;
    if (A1D_i != 5'd0) rd1_stored = regs[A1D_i];
    if (A2D_i != 5'd0) rd2_stored = regs[A2D_i];
  end

  // Read ports, optionally forwarding the value being written this cycle
  always_comb begin
`ifdef WB_REGFILE_BYPASS_EN
    RD1D_o = (wr_en && (A1D_i == rd_w)) ? result_w : rd1_stored;
    RD2D_o = (wr_en && (A2D_i == rd_w)) ? result_w : rd2_stored;
`else
    RD1D_o = rd1_stored;
    RD2D_o = rd2_stored;
`endif
  end

  assign ResultW_o   = result_w;
  assign RdW_o       = rd_w;
  assign RegWriteW_o = reg_write_w;
  assign a0_o        = regs[10];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, result mux, x0 protection, bypass timing, stall/flush, a0 tracking.
// Inputs change 1 time unit after the rising edge; outputs are checked in the same settled window.
// Expected values are hand-computed constants.
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        RegWriteM_i;
  logic [1:0]  ResultSrcM_i;
  logic [31:0] ALUResultM_i;
  logic [31:0] ReadDataM_i;
  logic [31:0] PCPlus4M_i;
  logic [4:0]  RdM_i;
  logic        StallW_i;
  logic        FlushW_i;
  logic [4:0]  A1D_i;
  logic [4:0]  A2D_i;
  logic [31:0] RD1D_o;
  logic [31:0] RD2D_o;
  logic [31:0] ResultW_o;
  logic [4:0]  RdW_o;
  logic        RegWriteW_o;
  logic [31:0] a0_o;

  int n_assert = 0;
  int n_fail   = 0;

  wb_regfile dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .RegWriteM_i  (RegWriteM_i),
    .ResultSrcM_i (ResultSrcM_i),
    .ALUResultM_i (ALUResultM_i),
    .ReadDataM_i  (ReadDataM_i),
    .PCPlus4M_i   (PCPlus4M_i),
    .RdM_i        (RdM_i),
    .StallW_i     (StallW_i),
    .FlushW_i     (FlushW_i),
    .A1D_i        (A1D_i),
    .A2D_i        (A2D_i),
    .RD1D_o       (RD1D_o),
    .RD2D_o       (RD2D_o),
    .ResultW_o    (ResultW_o),
    .RdW_o        (RdW_o),
    .RegWriteW_o  (RegWriteW_o),
    .a0_o         (a0_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset held with nonzero M inputs
    rst_n_i      = 1'b0;
    RegWriteM_i  = 1'b1;
    ResultSrcM_i = 2'b00;
    ALUResultM_i = 32'hA5A5_A5A5;
    ReadDataM_i  = 32'h1111_1111;
    PCPlus4M_i   = 32'h2222_2222;
    RdM_i        = 5'd5;
    StallW_i     = 1'b0;
    FlushW_i     = 1'b0;
    A1D_i        = 5'd0;
    A2D_i        = 5'd0;
    step();
    step();
    check("rst_regwrite", {31'd0, RegWriteW_o}, 32'd0);
    check("rst_rd",       {27'd0, RdW_o},       32'd0);
    check("rst_result",   ResultW_o,            32'd0);
    check("rst_a0",       a0_o,                 32'd0);
    for (int i = 1; i < 32; i++) begin
      A1D_i = 5'(i);
      A2D_i = 5'(32 - i);
      #1;
      check("rst_rd1", RD1D_o, 32'd0);
      check("rst_rd2", RD2D_o, 32'd0);
    end

    // Release reset, write x5 = 0x1234, then assert reset mid-cycle
    rst_n_i      = 1'b1;
    ALUResultM_i = 32'h0000_1234;
    RdM_i        = 5'd5;
    step();
    step();
    A1D_i = 5'd5;
    #1;
    check("x5_written", RD1D_o, 32'h0000_1234);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("x5_async_rst", RD1D_o, 32'd0);
    check("rd_async_rst", {27'd0, RdW_o}, 32'd0);
    RegWriteM_i = 1'b0;
    step();
    rst_n_i = 1'b1;

    // Result mux: all three sources distinct, select each in turn
    RegWriteM_i  = 1'b1;
    RdM_i        = 5'd7;
    ALUResultM_i = 32'hDEAD_BEEF;
    ReadDataM_i  = 32'h0000_00FF;
    PCPlus4M_i   = 32'h0000_0104;
    A1D_i        = 5'd7;
    A2D_i        = 5'd0;
    ResultSrcM_i = 2'b00;
    step();
    check("alu_resultw", ResultW_o, 32'hDEAD_BEEF);
    check("alu_rdw",     {27'd0, RdW_o}, 32'd7);
    check("alu_regwrw",  {31'd0, RegWriteW_o}, 32'd1);
    step();
    check("alu_x7", RD1D_o, 32'hDEAD_BEEF);
    ResultSrcM_i = 2'b01;
    step();
    step();
    check("load_x7", RD1D_o, 32'h0000_00FF);
    ResultSrcM_i = 2'b10;
    step();
    step();
    check("pc4_x7", RD1D_o, 32'h0000_0104);
    ResultSrcM_i = 2'b11;
    step();
    check("rsvd_resultw", ResultW_o, 32'd0);
    ResultSrcM_i = 2'b00;

    // x0 protection
    RdM_i        = 5'd0;
    ALUResultM_i = 32'hFFFF_FFFF;
    step();
    check("x0_rdw", {27'd0, RdW_o}, 32'd0);
    step();
    A1D_i = 5'd0;
    A2D_i = 5'd0;
    #1;
    check("x0_rd1", RD1D_o, 32'd0);
    check("x0_rd2", RD2D_o, 32'd0);

    // Bypass: x3 = 0x55, read in the cycle after the capture edge
    RdM_i        = 5'd3;
    ALUResultM_i = 32'h0000_0055;
    step();
    RegWriteM_i = 1'b0;
    A1D_i       = 5'd3;
    A2D_i       = 5'd3;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("byp_rd1_early", RD1D_o, 32'h0000_0055);
    check("byp_rd2_early", RD2D_o, 32'h0000_0055);
`else
    check("byp_rd1_early", RD1D_o, 32'd0);
    check("byp_rd2_early", RD2D_o, 32'd0);
`endif
    step();
    check("byp_rd1_late", RD1D_o, 32'h0000_0055);
    check("byp_rd2_late", RD2D_o, 32'h0000_0055);

    // Stall / flush
    RegWriteM_i  = 1'b1;
    RdM_i        = 5'd9;
    ALUResultM_i = 32'h0000_0011;
    step();
    check("cap_rdw",  {27'd0, RdW_o}, 32'd9);
    check("cap_resw", ResultW_o, 32'h0000_0011);
    StallW_i     = 1'b1;
    RdM_i        = 5'd12;
    ALUResultM_i = 32'h0000_0022;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_rdw",  {27'd0, RdW_o}, 32'd9);
      check("stall_resw", ResultW_o, 32'h0000_0011);
    end
    FlushW_i = 1'b1;
    step();
    check("flush_regwrw", {31'd0, RegWriteW_o}, 32'd0);
    check("flush_rdw",    {27'd0, RdW_o}, 32'd0);
    check("flush_resw",   ResultW_o, 32'd0);
    StallW_i    = 1'b0;
    FlushW_i    = 1'b0;
    RegWriteM_i = 1'b0;
    A1D_i       = 5'd9;
    A2D_i       = 5'd12;
    #1;
    check("flush_x9",  RD1D_o, 32'h0000_0011);
    check("flush_x12", RD2D_o, 32'd0);

    // a0 tracking
    RegWriteM_i  = 1'b1;
    RdM_i        = 5'd10;
    ALUResultM_i = 32'h0000_002A;
    step();
    RegWriteM_i = 1'b0;
    #1;
    check("a0_before", a0_o, 32'd0);
    step();
    check("a0_after", a0_o, 32'h0000_002A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
